// File: rtl/dpram_pkg.sv
// Shared types and the byte-lane merge helper for the dual-port RAM.
// The RAM top also honours DPRAM_FWD_EN (cross-port write forwarding).
package dpram_pkg;

    typedef enum logic {RDW_READ_FIRST, RDW_WRITE_FIRST} rdw_mode_e;
    typedef enum logic {CLEAR, IDLE} clr_state_e;

    localparam int MERGE_MAX_W = 256;
    localparam int MERGE_MAX_B = 256;

    // Callers zero-extend into the fixed width and truncate the result back.
    function automatic logic [MERGE_MAX_W-1:0] be_merge(
        input logic [MERGE_MAX_W-1:0] old_word,
        input logic [MERGE_MAX_W-1:0] new_word,
        input logic [MERGE_MAX_B-1:0] be,
        input int                     byte_width
    );
        logic [MERGE_MAX_W-1:0] res;
        for (int i = 0; i < MERGE_MAX_W; i++) begin
            res[i] = be[8'(i / byte_width)] ? new_word[i] : old_word[i];
        end
        return res;
    endfunction

endpackage

// File: rtl/dpram_port.sv
// One port's read-during-write select and read-latency output pipeline.
module dpram_port
    import dpram_pkg::*;
#(
    parameter int        DATA_WIDTH = 32,
    parameter int        RD_LATENCY = 1,
    parameter rdw_mode_e RDW_MODE   = RDW_READ_FIRST
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  acc_i,
    input  logic                  wr_i,
    input  logic [DATA_WIDTH-1:0] old_word_i,
    input  logic [DATA_WIDTH-1:0] new_word_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o
);

    logic [DATA_WIDTH-1:0] sel_word;
    logic [DATA_WIDTH-1:0] s1_data_q;
    logic                  s1_valid_q;

    assign sel_word = (RDW_MODE == RDW_WRITE_FIRST && wr_i) ? new_word_i : old_word_i;

    // Data registers only load on a completed access so the output holds otherwise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= acc_i;
            if (acc_i) s1_data_q <= sel_word;
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] s2_data_q;
        logic                  s2_valid_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                s2_data_q  <= '0;
                s2_valid_q <= 1'b0;
            end else begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) s2_data_q <= s1_data_q;
            end
        end

        assign rd_data_o  = s2_data_q;
        assign rd_valid_o = s2_valid_q;
    end else begin : g_lat1
        assign rd_data_o  = s1_data_q;
        assign rd_valid_o = s1_valid_q;
    end

endmodule

// File: rtl/dpram_be.sv
// True dual-port byte-enable RAM with post-reset clear sweep.
// Optional feature macro: DPRAM_FWD_EN (cross-port read-during-write forwarding).
module dpram_be
    import dpram_pkg::*;
#(
    parameter int        DATA_WIDTH = 32,
    parameter int        BYTE_WIDTH = 8,
    parameter int        DATA_DEPTH = 256,
    parameter int        RD_LATENCY = 1,
    parameter rdw_mode_e RDW_MODE   = RDW_READ_FIRST,
    localparam int       NUM_BYTES  = DATA_WIDTH / BYTE_WIDTH,
    localparam int       AW         = $clog2(DATA_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  busy,
    input  logic                  a_en,
    input  logic                  a_wr_en,
    input  logic [NUM_BYTES-1:0]  a_be,
    input  logic [AW-1:0]         a_addr,
    input  logic [DATA_WIDTH-1:0] a_wr_data,
    output logic [DATA_WIDTH-1:0] a_rd_data,
    output logic                  a_rd_valid,
    input  logic                  b_en,
    input  logic                  b_wr_en,
    input  logic [NUM_BYTES-1:0]  b_be,
    input  logic [AW-1:0]         b_addr,
    input  logic [DATA_WIDTH-1:0] b_wr_data,
    output logic [DATA_WIDTH-1:0] b_rd_data,
    output logic                  b_rd_valid
);

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("dpram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("dpram_be: RD_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH > MERGE_MAX_W) begin : g_too_wide
        $error("dpram_be: DATA_WIDTH exceeds merge helper width");
    end

    function automatic logic [DATA_WIDTH-1:0] merge_w(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NUM_BYTES-1:0]  be
    );
        return DATA_WIDTH'(be_merge(MERGE_MAX_W'(old_word), MERGE_MAX_W'(new_word),
                                    MERGE_MAX_B'(be), BYTE_WIDTH));
    endfunction

    clr_state_e            state_q;
    logic                  busy_q;
    logic [AW-1:0]         clr_addr_q;
    logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];

    logic                  a_acc, b_acc, a_in, b_in, a_wr, b_wr, collide, clr_we;
    logic [DATA_WIDTH-1:0] a_old, b_old, a_base, a_merged, b_merged;
    logic [DATA_WIDTH-1:0] a_rd_word, b_rd_word, a_new, b_new;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR;
            busy_q     <= 1'b1;
            clr_addr_q <= '0;
        end else if (state_q == CLEAR) begin
            if (clr_addr_q == AW'(DATA_DEPTH - 1)) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                clr_addr_q <= clr_addr_q + 1'b1;
            end
        end
    end

    assign busy   = busy_q;
    assign clr_we = (state_q == CLEAR) && !rst;
    assign a_acc  = a_en && !busy_q && !rst;
    assign b_acc  = b_en && !busy_q && !rst;

    if ((2 ** AW) == DATA_DEPTH) begin : g_pow2
        assign a_in = 1'b1;
        assign b_in = 1'b1;
    end else begin : g_npow2
        assign a_in = {1'b0, a_addr} < (AW + 1)'(DATA_DEPTH);
        assign b_in = {1'b0, b_addr} < (AW + 1)'(DATA_DEPTH);
    end

    assign a_old = a_in ? mem_q[a_addr] : '0;
    assign b_old = b_in ? mem_q[b_addr] : '0;
    assign a_wr  = a_acc && a_wr_en && a_in;
    assign b_wr  = b_acc && b_wr_en && b_in;

    // On a same-address double write, A's lanes are layered over B's merged word.
    assign collide  = a_wr && b_wr && (a_addr == b_addr);
    assign b_merged = merge_w(b_old, b_wr_data, b_be);
    assign a_base   = collide ? b_merged : a_old;
    assign a_merged = merge_w(a_base, a_wr_data, a_be);

    assign a_new = a_in ? a_merged : '0;
    assign b_new = collide ? a_merged : (b_in ? b_merged : '0);

`ifdef DPRAM_FWD_EN
    assign a_rd_word = (b_wr && !a_wr_en && a_addr == b_addr) ? b_merged : a_old;
    assign b_rd_word = (a_wr && !b_wr_en && a_addr == b_addr) ? a_merged : b_old;
`else
    assign a_rd_word = a_old;
    assign b_rd_word = b_old;
`endif

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr_q] <= '0;
        end else begin
            if (b_wr) mem_q[b_addr] <= b_merged;
            if (a_wr) mem_q[a_addr] <= a_merged;
        end
    end

    dpram_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY),
        .RDW_MODE   (RDW_MODE)
    ) u_port_a (
        .clk_i      (clk),
        .rst_i      (rst),
        .acc_i      (a_acc),
        .wr_i       (a_wr_en),
        .old_word_i (a_rd_word),
        .new_word_i (a_new),
        .rd_data_o  (a_rd_data),
        .rd_valid_o (a_rd_valid)
    );

    dpram_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY),
        .RDW_MODE   (RDW_MODE)
    ) u_port_b (
        .clk_i      (clk),
        .rst_i      (rst),
        .acc_i      (b_acc),
        .wr_i       (b_wr_en),
        .old_word_i (b_rd_word),
        .new_word_i (b_new),
        .rd_data_o  (b_rd_data),
        .rd_valid_o (b_rd_valid)
    );

endmodule

// File: tb/tb_dpram_be.sv
// Bench for dpram_be: latency-1 read-first and latency-2 write-first instances share stimulus.
module tb_dpram_be;
    import dpram_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_en = 1'b0, a_wr_en = 1'b0, b_en = 1'b0, b_wr_en = 1'b0;
    logic [3:0]  a_be = '0, b_be = '0, a_addr = '0, b_addr = '0;
    logic [31:0] a_wr_data = '0, b_wr_data = '0;

    logic        busy1, busy2, a_rd_valid1, b_rd_valid1, a_rd_valid2, b_rd_valid2;
    logic [31:0] a_rd_data1, b_rd_data1, a_rd_data2, b_rd_data2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int clr_left = -1;
    bit mon_en   = 1'b0;

    logic [31:0] m [DEPTH];
    logic [31:0] exp_q [4][$];
    int          due_q [4][$];

    logic [31:0] mon_data [4];
    logic        mon_vld  [4];
    logic [31:0] mon_d;
    int          mon_t;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dpram_be #(
        .DATA_WIDTH(32), .BYTE_WIDTH(8), .DATA_DEPTH(DEPTH),
        .RD_LATENCY(1), .RDW_MODE(RDW_READ_FIRST)
    ) u_dut1 (
        .clk(clk), .rst(rst), .busy(busy1),
        .a_en(a_en), .a_wr_en(a_wr_en), .a_be(a_be), .a_addr(a_addr),
        .a_wr_data(a_wr_data), .a_rd_data(a_rd_data1), .a_rd_valid(a_rd_valid1),
        .b_en(b_en), .b_wr_en(b_wr_en), .b_be(b_be), .b_addr(b_addr),
        .b_wr_data(b_wr_data), .b_rd_data(b_rd_data1), .b_rd_valid(b_rd_valid1)
    );

    dpram_be #(
        .DATA_WIDTH(32), .BYTE_WIDTH(8), .DATA_DEPTH(DEPTH),
        .RD_LATENCY(2), .RDW_MODE(RDW_WRITE_FIRST)
    ) u_dut2 (
        .clk(clk), .rst(rst), .busy(busy2),
        .a_en(a_en), .a_wr_en(a_wr_en), .a_be(a_be), .a_addr(a_addr),
        .a_wr_data(a_wr_data), .a_rd_data(a_rd_data2), .a_rd_valid(a_rd_valid2),
        .b_en(b_en), .b_wr_en(b_wr_en), .b_be(b_be), .b_addr(b_addr),
        .b_wr_data(b_wr_data), .b_rd_data(b_rd_data2), .b_rd_valid(b_rd_valid2)
    );

    // Scoreboard index: 0 = dut1 A, 1 = dut1 B, 2 = dut2 A, 3 = dut2 B.
    assign mon_data[0] = a_rd_data1;  assign mon_vld[0] = a_rd_valid1;
    assign mon_data[1] = b_rd_data1;  assign mon_vld[1] = b_rd_valid1;
    assign mon_data[2] = a_rd_data2;  assign mon_vld[2] = a_rd_valid2;
    assign mon_data[3] = b_rd_data2;  assign mon_vld[3] = b_rd_valid2;

    always @(negedge clk) begin
        if (mon_en) begin
            for (int p = 0; p < 4; p++) begin
                if (mon_vld[p] === 1'b1) begin
                    checks++;
                    if (exp_q[p].size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_valid sb%0d cyc=%0d got=%h exp=no_strobe", p, cyc, mon_data[p]);
                    end else begin
                        mon_d = exp_q[p].pop_front();
                        mon_t = due_q[p].pop_front();
                        if (mon_data[p] !== mon_d || mon_t != cyc) begin
                            failures++;
                            $display("FAIL rd_data sb%0d cyc=%0d got=%h exp=%h due_cyc=%0d", p, cyc, mon_data[p], mon_d, mon_t);
                        end
                    end
                end else if (mon_vld[p] !== 1'b0 || (due_q[p].size() > 0 && due_q[p][0] <= cyc)) begin
                    checks++;
                    failures++;
                    $display("FAIL missing_valid sb%0d cyc=%0d got_valid=%b exp_valid=1", p, cyc, mon_vld[p]);
                    if (due_q[p].size() > 0) begin
                        void'(exp_q[p].pop_front());
                        void'(due_q[p].pop_front());
                    end
                end
            end
        end
    end

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? n[8*i +: 8] : o[8*i +: 8];
        return r;
    endfunction

    // One clock of stimulus; the model decides acceptance and pushes expected words.
    task automatic do_cycle(input logic r,
                            input logic ae, input logic aw, input logic [3:0] abe, input logic [3:0] aa, input logic [31:0] ad,
                            input logic be_, input logic bw, input logic [3:0] bbe, input logic [3:0] ba, input logic [31:0] bd);
        logic [31:0] old_a, old_b, e1, e2;
        logic        busy_exp;
        @(negedge clk);
        if (!r && clr_left >= 0) begin
            busy_exp = (clr_left > 0);
            checks++;
            if (busy1 !== busy_exp || busy2 !== busy_exp) begin
                failures++;
                $display("FAIL busy cyc=%0d got=%b/%b exp=%b", cyc, busy1, busy2, busy_exp);
            end
        end
        rst = r;
        a_en = ae; a_wr_en = aw; a_be = abe; a_addr = aa; a_wr_data = ad;
        b_en = be_; b_wr_en = bw; b_be = bbe; b_addr = ba; b_wr_data = bd;
        if (r) begin
            clr_left = DEPTH;
            return;
        end
        if (clr_left > 0) begin
            clr_left--;
            if (clr_left == 0) for (int i = 0; i < DEPTH; i++) m[i] = '0;
            return;
        end
        old_a = m[aa];
        old_b = m[ba];
        if (be_ && bw) m[ba] = merge(m[ba], bd, bbe);
        if (ae && aw) m[aa] = merge(m[aa], ad, abe);
        if (ae) begin
            e1 = old_a;
            e2 = aw ? m[aa] : old_a;
`ifdef DPRAM_FWD_EN
            if (!aw && be_ && bw && ba == aa) begin e1 = m[aa]; e2 = m[aa]; end
`endif
            exp_q[0].push_back(e1); due_q[0].push_back(cyc + 1);
            exp_q[2].push_back(e2); due_q[2].push_back(cyc + 2);
        end
        if (be_) begin
            e1 = old_b;
            e2 = bw ? m[ba] : old_b;
`ifdef DPRAM_FWD_EN
            if (!bw && ae && aw && ba == aa) begin e1 = m[ba]; e2 = m[ba]; end
`endif
            exp_q[1].push_back(e1); due_q[1].push_back(cyc + 1);
            exp_q[3].push_back(e2); due_q[3].push_back(cyc + 2);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) do_cycle(0, 0, 0, 4'h0, 4'h0, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0);
    endtask

    task automatic acc_a(input logic wr, input logic [3:0] be, input logic [3:0] addr, input logic [31:0] d);
        do_cycle(0, 1, wr, be, addr, d, 0, 0, 4'h0, 4'h0, 32'h0);
    endtask

    task automatic acc_b(input logic wr, input logic [3:0] be, input logic [3:0] addr, input logic [31:0] d);
        do_cycle(0, 0, 0, 4'h0, 4'h0, 32'h0, 1, wr, be, addr, d);
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({a_rd_data1, b_rd_data1, a_rd_data2, b_rd_data2} !== '0 ||
            {a_rd_valid1, b_rd_valid1, a_rd_valid2, b_rd_valid2} !== 4'b0) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h/%h/%h/%h vld=%b%b%b%b exp=all_zero", name, cyc,
                     a_rd_data1, b_rd_data1, a_rd_data2, b_rd_data2,
                     a_rd_valid1, b_rd_valid1, a_rd_valid2, b_rd_valid2);
        end
    endtask

    task automatic read_all_zero();
        for (int i = 0; i < DEPTH; i++)
            do_cycle(0, 1, 0, 4'h0, 4'(i), 32'h0, 1, 0, 4'h0, 4'(DEPTH - 1 - i), 32'h0);
    endtask

    task automatic test_reset();
        do_cycle(1, 0, 0, 4'h0, 4'h0, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0);
        do_cycle(1, 0, 0, 4'h0, 4'h0, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0);
        mon_en = 1'b1;
        // Requests during the sweep must be dropped.
        acc_a(0, 4'h0, 4'd3, 32'h0);
        check_outputs_zero("reset_outputs");
        acc_b(1, 4'hF, 4'd4, 32'h5555_AAAA);
        check_outputs_zero("reset_outputs");
        for (int i = 0; i < DEPTH - 2; i++) begin
            idle(1);
            check_outputs_zero("reset_outputs");
        end
        read_all_zero();
        idle(3);
    endtask

    task automatic test_byte_enables();
        acc_a(1, 4'hF, 4'd5, 32'hAABB_CCDD);
        acc_a(1, 4'b0101, 4'd5, 32'h1122_3344);
        acc_b(0, 4'h0, 4'd5, 32'h0);
        idle(4);
        checks++;
        if (b_rd_data1 !== 32'hAA22_CC44 || b_rd_data2 !== 32'hAA22_CC44 || b_rd_valid1 !== 1'b0) begin
            failures++;
            $display("FAIL be_hold got=%h/%h vld=%b exp=aa22cc44 vld=0", b_rd_data1, b_rd_data2, b_rd_valid1);
        end
        checks++;
        if (a_rd_data1 !== 32'hAABB_CCDD || a_rd_data2 !== 32'hAA22_CC44) begin
            failures++;
            $display("FAIL be_write_return got=%h/%h exp=aabbccdd/aa22cc44", a_rd_data1, a_rd_data2);
        end
    endtask

    task automatic test_rdw();
        acc_a(1, 4'hF, 4'd3, 32'h1);
        acc_a(1, 4'hF, 4'd3, 32'h2);
        idle(3);
        checks++;
        if (a_rd_data1 !== 32'h1 || a_rd_data2 !== 32'h2) begin
            failures++;
            $display("FAIL rdw_mode got=%h/%h exp=00000001/00000002", a_rd_data1, a_rd_data2);
        end
    endtask

    task automatic test_dual_write();
        do_cycle(0, 1, 1, 4'b1100, 4'd7, 32'hFFFF_0000, 1, 1, 4'hF, 4'd7, 32'h1234_5678);
        acc_a(0, 4'h0, 4'd7, 32'h0);
        idle(3);
        checks++;
        if (a_rd_data1 !== 32'hFFFF_5678 || a_rd_data2 !== 32'hFFFF_5678) begin
            failures++;
            $display("FAIL dual_write got=%h/%h exp=ffff5678", a_rd_data1, a_rd_data2);
        end
    endtask

    task automatic test_cross_rdw();
        do_cycle(0, 1, 1, 4'hF, 4'd9, 32'hDEAD_BEEF, 1, 0, 4'h0, 4'd9, 32'h0);
        acc_b(0, 4'h0, 4'd9, 32'h0);
        idle(3);
        checks++;
        if (b_rd_data1 !== 32'hDEAD_BEEF || b_rd_data2 !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL cross_followup got=%h/%h exp=deadbeef", b_rd_data1, b_rd_data2);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 120; i++) begin
            do_cycle(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, DEPTH - 1)), $urandom,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, DEPTH - 1)), $urandom);
        end
        idle(4);
    endtask

    task automatic test_reset_mid_clear();
        do_cycle(1, 0, 0, 4'h0, 4'h0, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0);
        idle(8);
        do_cycle(1, 0, 0, 4'h0, 4'h0, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            idle(1);
            check_outputs_zero("midclear_outputs");
        end
        read_all_zero();
        idle(4);
    endtask

    task automatic test_drain();
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (exp_q[p].size() != 0) begin
                failures++;
                $display("FAIL drain sb%0d got=%0d_pending exp=0", p, exp_q[p].size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_byte_enables();
        test_rdw();
        test_dual_write();
        test_cross_rdw();
        test_back_to_back();
        test_reset_mid_clear();
        test_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
